// File: rtl/decode_stage.sv
// decode_stage: pipelined RV32I(+M) decode with D/E register, handshake, load-use bubbles and bubble counter
module decode_stage #(
    parameter int XLEN            = 32,
    parameter int M_EXT           = 1,
    parameter int LOAD_USE_DETECT = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic             out_funct7b5,
    output logic             Branch,
    output logic             Jump,
    output logic             MemWrite,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             RegWrite,
    output logic             LdSrc,
    output logic             StSrc,
    output logic             JalSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             out_muldiv,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_JALR = 7'b1100111, OP_S = 7'b0100011, OP_B = 7'b1100011,
                           OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;

    // ctrl = {Branch, Jump, ResultSrc[1:0], MemWrite, ALUSrcA, ALUSrcB, ImmSrc[2:0], RegWrite, ALUOp[1:0], LdSrc, StSrc, JalSrc}
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic            f7b5;
        logic [15:0]     ctrl;
        logic            muldiv;
        logic            illegal;
    } de_t;

    de_t              r_de;
    de_t              w_dec;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      w_ctrl;
    logic             w_legal;
    logic             w_use1;
    logic             w_use2;
    logic             w_hazard;
    wire  [6:0]       w_op = instr[6:0];
    wire  [2:0]       w_f3 = instr[14:12];
    wire  [6:0]       w_f7 = instr[31:25];

    always_comb begin
        w_ctrl  = '0;
        w_legal = 1'b1;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        case (w_op)
            OP_R: begin
                w_ctrl  = 16'b0_0_00_0_0_0_000_1_10_0_0_0;
                w_legal = w_f7 == 7'b0000000 || w_f7 == 7'b0100000 || (M_EXT != 0 && w_f7 == 7'b0000001);
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            OP_I: begin
                w_ctrl = 16'b0_0_00_0_0_1_000_1_00_0_0_0;
                w_use1 = 1'b1;
            end
            OP_L: begin
                w_ctrl = {13'b0_0_01_0_0_1_000_1_00, w_f3[2], 2'b00};
                w_use1 = 1'b1;
            end
            OP_JALR: begin
                w_ctrl = 16'b0_1_10_0_0_1_000_1_00_0_0_0;
                w_use1 = 1'b1;
            end
            OP_S: begin
                w_ctrl = {13'b0_0_00_1_0_1_001_0_00, 1'b0, ~|w_f3, 1'b0};
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_B: begin
                w_ctrl = 16'b1_0_00_0_0_0_010_0_01_0_0_1;
                w_use1 = 1'b1;
                w_use2 = 1'b1;
            end
            OP_LUI:   w_ctrl = 16'b0_0_00_0_0_1_100_1_11_0_0_0;
            OP_AUIPC: w_ctrl = 16'b0_0_00_0_1_1_100_1_11_0_0_0;
            OP_JAL:   w_ctrl = 16'b0_1_10_0_0_0_011_1_00_0_0_1;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_dec         = '0;
        w_dec.valid   = 1'b1;
        w_dec.pc      = pc;
        w_dec.rs1     = instr[19:15];
        w_dec.rs2     = instr[24:20];
        w_dec.rd      = instr[11:7];
        w_dec.f3      = w_f3;
        w_dec.f7b5    = instr[30];
        w_dec.ctrl    = w_legal ? w_ctrl : 16'd0;
        w_dec.muldiv  = M_EXT != 0 && w_op == OP_R && w_f7 == 7'b0000001;
        w_dec.illegal = !w_legal;
    end

    // A load in D/E whose destination feeds the incoming instruction needs one bubble
    assign w_hazard = LOAD_USE_DETECT != 0 && in_valid && r_de.valid && r_de.ctrl[13:12] == 2'b01 &&
                      r_de.rd != 5'd0 && ((instr[19:15] == r_de.rd && w_use1) || (instr[24:20] == r_de.rd && w_use2));
    assign in_ready = !stall && !flush && !w_hazard;

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && (w_hazard || !in_valid)))
            r_de <= '0;
        else if (!stall)
            r_de <= w_dec;
        if (rst)
            r_cnt <= '0;
        else if (!flush && !stall && w_hazard && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign out_valid    = r_de.valid;
    assign out_pc       = r_de.pc;
    assign out_rs1      = r_de.rs1;
    assign out_rs2      = r_de.rs2;
    assign out_rd       = r_de.rd;
    assign out_funct3   = r_de.f3;
    assign out_funct7b5 = r_de.f7b5;
    assign {Branch, Jump, ResultSrc, MemWrite, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUOp, LdSrc, StSrc, JalSrc} = r_de.ctrl;
    assign out_muldiv   = r_de.muldiv;
    assign out_illegal  = r_de.illegal;
    assign bubble_cnt   = r_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (M_EXT=1 small-counter instance plus an M_EXT=0 instance)
module tb_decode_stage;
    localparam int CW = 4;

    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic [2:0]    f3;
        logic          f7b5;
        logic [15:0]   ctrl;
        logic          muldiv;
        logic          illegal;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk, rst, in_valid, stall, flush;
    logic [31:0] instr, pc;

    logic          a_ready, a_valid, a_f7b5, a_br, a_jp, a_mw, a_sa, a_sb, a_rw, a_ld, a_st, a_jal, a_md, a_ill;
    logic [31:0]   a_pc;
    logic [4:0]    a_rs1, a_rs2, a_rd;
    logic [2:0]    a_f3, a_imm;
    logic [1:0]    a_rs, a_aop;
    logic [CW-1:0] a_cnt;

    logic          b_ready, b_valid, b_f7b5, b_br, b_jp, b_mw, b_sa, b_sb, b_rw, b_ld, b_st, b_jal, b_md, b_ill;
    logic [31:0]   b_pc;
    logic [4:0]    b_rs1, b_rs2, b_rd;
    logic [2:0]    b_f3, b_imm;
    logic [1:0]    b_rs, b_aop;
    logic [15:0]   b_cnt;

    wire [15:0] a_ctrl = {a_br, a_jp, a_rs, a_mw, a_sa, a_sb, a_imm, a_rw, a_aop, a_ld, a_st, a_jal};

    decode_stage #(.XLEN(32), .M_EXT(1), .LOAD_USE_DETECT(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(a_valid), .out_pc(a_pc), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_rd(a_rd), .out_funct3(a_f3), .out_funct7b5(a_f7b5), .Branch(a_br),
        .Jump(a_jp), .MemWrite(a_mw), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .RegWrite(a_rw), .LdSrc(a_ld),
        .StSrc(a_st), .JalSrc(a_jal), .ResultSrc(a_rs), .ALUOp(a_aop), .ImmSrc(a_imm),
        .out_muldiv(a_md), .out_illegal(a_ill), .bubble_cnt(a_cnt));

    decode_stage #(.XLEN(32), .M_EXT(0), .LOAD_USE_DETECT(1), .CNT_W(16)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .out_valid(b_valid), .out_pc(b_pc), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_rd(b_rd), .out_funct3(b_f3), .out_funct7b5(b_f7b5), .Branch(b_br),
        .Jump(b_jp), .MemWrite(b_mw), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .RegWrite(b_rw), .LdSrc(b_ld),
        .StSrc(b_st), .JalSrc(b_jal), .ResultSrc(b_rs), .ALUOp(b_aop), .ImmSrc(b_imm),
        .out_muldiv(b_md), .out_illegal(b_ill), .bubble_cnt(b_cnt));

    int   checks = 0;
    int   errors = 0;
    exp_t m;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the control table
    function automatic exp_t dec(input logic [31:0] ins, input logic [31:0] p);
        exp_t e;
        logic [6:0] f7;
        e = '0;
        f7 = ins[31:25];
        e.valid = 1'b1;
        e.pc = p;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.f3 = ins[14:12];
        e.f7b5 = ins[30];
        case (ins[6:0])
            7'b0110011: begin
                if (f7 == 7'd0 || f7 == 7'b0100000 || f7 == 7'b0000001) e.ctrl = 16'b0000000000110000;
                else e.illegal = 1'b1;
                e.muldiv = f7 == 7'b0000001;
            end
            7'b0010011: e.ctrl = 16'b0000001000100000;
            7'b0000011: e.ctrl = ins[14] ? 16'b0001001000100100 : 16'b0001001000100000;
            7'b1100111: e.ctrl = 16'b0110001000100000;
            7'b0100011: e.ctrl = (ins[14:12] == 3'd0) ? 16'b0000101001000010 : 16'b0000101001000000;
            7'b1100011: e.ctrl = 16'b1000000010001001;
            7'b0110111: e.ctrl = 16'b0000001100111000;
            7'b0010111: e.ctrl = 16'b0000011100111000;
            7'b1101111: e.ctrl = 16'b0110000011100001;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic hz(input exp_t d, input logic v, input logic [31:0] ins);
        logic u1, u2;
        u1 = ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
        u2 = ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        return v && d.valid && d.ctrl[13:12] == 2'b01 && d.rd != 5'd0 &&
               ((ins[19:15] == d.rd && u1) || (ins[24:20] == d.rd && u2));
    endfunction

    task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic st, input logic fl);
        exp_t nxt, e;
        logic h;
        in_valid = v;
        instr = ins;
        pc = p;
        stall = st;
        flush = fl;
        #1;
        h = hz(m, v, ins);
        chk({tag, ".in_ready"}, 64'(a_ready), 64'(!st && !fl && !h));
        nxt = '0;
        nxt.cnt = m.cnt;
        if (fl) nxt = '0;
        else if (st) nxt = m;
        else if (h) nxt.cnt = (m.cnt == {CW{1'b1}}) ? m.cnt : m.cnt + 1'b1;
        else if (v) nxt = dec(ins, p);
        if (fl || (!st && !h && v)) nxt.cnt = m.cnt;
        q.push_back(nxt);
        @(posedge clk);
        #1;
        e = q.pop_front();
        m = e;
        chk({tag, ".valid"}, 64'(a_valid), 64'(e.valid));
        chk({tag, ".ctrl"}, 64'(a_ctrl), 64'(e.ctrl));
        chk({tag, ".muldiv"}, 64'(a_md), 64'(e.muldiv));
        chk({tag, ".illegal"}, 64'(a_ill), 64'(e.illegal));
        chk({tag, ".cnt"}, 64'(a_cnt), 64'(e.cnt));
        if (e.valid)
            chk({tag, ".fields"}, {a_pc, a_rs1, a_rs2, a_rd, a_f3, a_f7b5},
                {e.pc, e.rs1, e.rs2, e.rd, e.f3, e.f7b5});
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        instr = '0;
        pc = '0;
        stall = 1'b0;
        flush = 1'b0;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset.valid", 64'(a_valid), 64'd0);
        chk("reset.ctrl", 64'({a_ctrl, a_md, a_ill}), 64'd0);
        chk("reset.cnt", 64'(a_cnt), 64'd0);
        chk("reset.in_ready", 64'(a_ready), 64'd1);

        step("add", 1, 32'h002081B3, 32'h100, 0, 0);
        step("lw", 1, 32'h0000A283, 32'h104, 0, 0);
        step("sb", 1, 32'h00208023, 32'h108, 0, 0);
        step("beq", 1, 32'h00208063, 32'h10C, 0, 0);
        step("lui", 1, 32'h123452B7, 32'h110, 0, 0);
        step("auipc", 1, 32'h00001297, 32'h114, 0, 0);
        step("jal", 1, 32'h000000EF, 32'h118, 0, 0);
        step("jalr", 1, 32'h00008067, 32'h11C, 0, 0);
        step("lbu", 1, 32'h0000C283, 32'h120, 0, 0);
        chk("lbu.LdSrc", 64'(a_ld), 64'd1);
        step("sub", 1, 32'h40208133, 32'h124, 0, 0);
        step("idle", 0, 32'h0, 32'h0, 0, 0);

        step("lu.lw", 1, 32'h0000A283, 32'h200, 0, 0);
        step("lu.bubble", 1, 32'h00728333, 32'h204, 0, 0);
        chk("lu.bubble_valid", 64'(a_valid), 64'd0);
        step("lu.add", 1, 32'h00728333, 32'h204, 0, 0);
        chk("lu.cnt_one", 64'(a_cnt), 64'd1);
        step("x0.lw", 1, 32'h0000A003, 32'h208, 0, 0);
        step("x0.add", 1, 32'h00700333, 32'h20C, 0, 0);
        step("addi.lw", 1, 32'h0000A283, 32'h210, 0, 0);
        step("addi.addi", 1, 32'h00138313, 32'h214, 0, 0);
        chk("addi.cnt_same", 64'(a_cnt), 64'd1);

        step("st.load", 1, 32'h002081B3, 32'h300, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 1, 32'h00208063, 32'h304, 1, 0);
        chk("stall.pc_frozen", 64'(a_pc), 64'h300);
        step("flush_stall", 1, 32'h00208063, 32'h304, 1, 1);

        step("mul", 1, 32'h02208133, 32'h400, 0, 0);
        chk("mul.m0.illegal", 64'({b_valid, b_ill, b_rw, b_md}), 64'b1100);
        step("f7bad", 1, 32'h20208133, 32'h404, 0, 0);
        step("op7f", 1, 32'h0000007F, 32'h408, 0, 0);
        chk("op7f.MemWrite", 64'(a_mw), 64'd0);

        for (int i = 0; i < (1 << CW) + 3; i++) begin
            step("sat.lw", 1, 32'h0000A283, 32'h500, 0, 0);
            step("sat.bubble", 1, 32'h00728333, 32'h504, 0, 0);
            step("sat.add", 1, 32'h00728333, 32'h504, 0, 0);
        end
        chk("sat.cnt", 64'(a_cnt), 64'({CW{1'b1}}));

        step("rst.lw", 1, 32'h0000A283, 32'h600, 0, 0);
        in_valid = 1'b1;
        instr = 32'h00728333;
        stall = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        m = '0;
        #1;
        chk("rst_mid.valid", 64'({a_valid, a_ctrl}), 64'd0);
        chk("rst_mid.cnt", 64'(a_cnt), 64'd0);
        step("post_rst", 1, 32'h002081B3, 32'h700, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined RV32I(+M) instruction decode stage. Sits between the fetch and execute pipeline registers and supersedes the combinational main decoder for the pipelined core.
- Decodes opcode/funct3/funct7 into the core's control bundle and registers it with operand fields into the D/E pipeline register.
- Provides valid/ready handshake, stall, flush, load-use bubble insertion, illegal-instruction flagging and a bubble performance counter.

Parameters:
- XLEN, 32, PC width.
- M_EXT, 1, when 1 accept R-type funct7=0000001 (MUL/DIV) and assert out_muldiv.
- LOAD_USE_DETECT, 1, when 1 enable internal load-use hazard bubble insertion.
- CNT_W, 16, width of bubble counter (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage accepts instruction this cycle (combinational)
- instr  in  32  instruction word
- pc  in  XLEN  instruction PC
- stall  in  1  hold D/E register
- flush  in  1  replace D/E contents with bubble
- out_valid  out  1  D/E register holds real instruction
- out_pc  out  XLEN  registered PC
- out_rs1, out_rs2, out_rd  out  5 each  register fields
- out_funct3  out  3  ; out_funct7b5  out  1
- Branch, Jump, MemWrite, ALUSrcA, ALUSrcB, RegWrite, LdSrc, StSrc, JalSrc  out  1 each
- ResultSrc  out  2 ; ALUOp  out  2 ; ImmSrc  out  3
- out_muldiv  out  1  M-extension op
- out_illegal  out  1  unsupported encoding
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Control table (Br Jp ResultSrc MW SA SB ImmSrc RW ALUOp Ld St Jal):
  - R 0110011: 0 0 00 0 0 0 000 1 10 0 0 0
  - I-ALU 0010011: 0 0 00 0 0 1 000 1 00 0 0 0
  - Load 0000011: 0 0 01 0 0 1 000 1 00 f3[2] 0 0
  - JALR 1100111: 0 1 10 0 0 1 000 1 00 0 0 0
  - S 0100011: 0 0 00 1 0 1 001 0 00 0 ~|f3 0
  - B 1100011: 1 0 00 0 0 0 010 0 01 0 0 1
  - LUI 0110111: 0 0 00 0 0 1 100 1 11 0 0 0
  - AUIPC 0010111: 0 0 00 0 1 1 100 1 11 0 0 0
  - JAL 1101111: 0 1 10 0 0 0 011 1 00 0 0 1
- Illegal encodings:
  - Any other opcode.
  - R-type funct7 not in {0000000, 0100000}, plus 0000001 when M_EXT=1.
  - For either: all controls 0, out_illegal=1, out_valid=1 (execute raises the trap).
- Invalid-entry rule: when out_valid=0, every control output, out_muldiv and out_illegal are 0.
- Latency: 1 cycle, instr accepted at edge N → outputs valid after edge N.
- Hazard (LOAD_USE_DETECT=1), all of these must hold:
  - in_valid=1, out_valid=1, ResultSrc==01, out_rd!=0.
  - Either instr.rs1==out_rd and the opcode uses rs1 (R, I-ALU, Load, JALR, S, B), or instr.rs2==out_rd and the opcode uses rs2 (R, S, B).
- in_ready = !stall && !flush && !hazard.
- Register update priority at each edge:
  1. rst: out_valid=0, all controls/fields/flags 0, bubble_cnt=0.
  2. flush: bubble (out_valid=0, controls 0). Overrides stall, and any instruction presented is dropped.
  3. stall: all registers hold, including bubble_cnt.
  4. hazard: bubble inserted, bubble_cnt += 1 (saturates at all-ones), instruction held upstream.
  5. in_valid=1: load decoded instruction.
  6. in_valid=0: bubble.
- One hazard costs exactly one bubble: after the bubble out_valid=0, so the held instruction loads next cycle.
- Reset mid-stall or mid-hazard: rst wins, and the state is as after reset on the next cycle.

Test Plan:
- Reset → out_valid=0, all controls 0, bubble_cnt=0, in_ready=1.
- Decode sequence ADD x3,x1,x2 / LW x5,0(x1) / SB / BEQ / LUI / AUIPC / JAL / JALR, one per cycle:
  - Each output one cycle later matches the table row.
  - LW gives LdSrc=0, LBU gives LdSrc=1, SB gives StSrc=1.
- LW x5,0(x1), then ADD x6,x5,x7 → in_ready=0 for one cycle, one bubble (out_valid=0), ADD appears next cycle, bubble_cnt=1.
  - Repeat with rd=x0 or ADDI x6,x7,1 reading x7 → no bubble.
- stall=1 for 3 cycles with in_valid=1 → outputs frozen, in_ready=0.
  - flush together with stall → bubble next cycle.
- instr=0x02208133 (MUL): with M_EXT=1 → out_muldiv=1, RegWrite=1, ALUOp=10; with M_EXT=0 → out_illegal=1, RegWrite=0.
  - Opcode 0x7F → out_illegal=1, MemWrite=0.
- Force 2^CNT_W+3 load-use hazards → bubble_cnt saturates at all-ones.
